// File: rtl/peripheral_tap_pkg.sv
// Shared types for the TAP result collector: FSM state encoding and record field sizing.
// No logic of its own; latency and backpressure belong to the modules that import it.
package peripheral_tap_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tap_state_e;

    // Channel-index width; a single channel still needs a one-bit field.
    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/peripheral_tap_fifo.sv
// Generic first-word-fall-through FIFO; head visible the cycle after push, pop on pop & !empty.
// Backpressure: push ignored while full (count registered, a same-cycle pop does not free space).
module peripheral_tap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/peripheral_tap_collector.sv
// Round-robin collector of checker results into numbered TAP records; accept in t, record on out_* in t+1.
// Backpressure: no grant while the record FIFO is full or the plan is complete; out_* hold while !out_ready.
module peripheral_tap_collector
    import peripheral_tap_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 8,
    parameter int IDW       = 8,
    parameter int CNTW      = 16,
    parameter int NUM_TESTS = 0,
    localparam int CHW      = chan_width(CHANNELS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CHANNELS-1:0]     ch_valid,
    input  logic [CHANNELS-1:0]     ch_ok,
    input  logic [CHANNELS*IDW-1:0] ch_id,
    output logic [CHANNELS-1:0]     ch_ready,
    input  logic [CNTW-1:0]         plan_i,
    input  logic                    plan_we,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CNTW-1:0]         out_index,
    output logic                    out_ok,
    output logic [CHW-1:0]          out_chan,
    output logic [IDW-1:0]          out_id,
    output logic [CNTW-1:0]         pass_cnt,
    output logic [CNTW-1:0]         fail_cnt,
    output logic                    done,
    output logic                    plan_err
);

    typedef struct packed {
        logic [CNTW-1:0] index;
        logic            ok;
        logic [CHW-1:0]  chan;
        logic [IDW-1:0]  id;
    } tap_rec_t;

    localparam int RECW = $bits(tap_rec_t);
    localparam int FCW  = $clog2(DEPTH) + 1;
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;
    localparam logic [CHW-1:0]  CH_ONE   = CHW'(1);
    localparam logic [CHW-1:0]  LAST_CH  = CHW'(CHANNELS - 1);
    localparam logic [FCW-1:0]  FIFO_ONE = FCW'(1);

    tap_state_e      state_q, state_d;
    logic [CNTW-1:0] plan_q, plan_d;
    logic [CNTW-1:0] acc_q, acc_d;
    logic [CNTW-1:0] pass_q, pass_d;
    logic [CNTW-1:0] fail_q, fail_d;
    logic [CHW-1:0]  ptr_q, ptr_d;
    logic            err_q, err_d;

    logic            gnt_any;
    logic [CHW-1:0]  gnt_idx;
    logic            can_grant;
    logic            accept;
    logic            plan_hit;
    logic            fifo_push, fifo_full, fifo_empty, fifo_drains;
    logic [FCW-1:0]  fifo_count;
    logic [RECW-1:0] fifo_head;
    tap_rec_t        push_rec, head_rec;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!gnt_any && ch_valid[(int'(ptr_q) + k) % CHANNELS]) begin
                gnt_any = 1'b1;
                gnt_idx = CHW'((int'(ptr_q) + k) % CHANNELS);
            end
        end
    end

    assign can_grant = (state_q != DONE) && !fifo_full;
    assign accept    = can_grant && gnt_any;
    assign plan_hit  = (plan_q != '0) && (acc_q == plan_q);

    always_comb begin
        ch_ready = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            ch_ready[k] = accept && (gnt_idx == CHW'(k));
        end
    end

    always_comb begin
        push_rec.index = acc_q + CNT_ONE;
        push_rec.ok    = ch_ok[gnt_idx];
        push_rec.chan  = gnt_idx;
        push_rec.id    = ch_id[int'(gnt_idx)*IDW +: IDW];
    end

    // Queue is empty after this edge: nothing new arrives and nothing (or only the last entry) is left.
    assign fifo_drains = !fifo_push &&
                         (fifo_empty || ((fifo_count == FIFO_ONE) && out_ready));

    always_comb begin
        state_d   = state_q;
        plan_d    = plan_q;
        acc_d     = acc_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ptr_d     = ptr_q;
        err_d     = err_q;
        fifo_push = 1'b0;

        if (accept) begin
            ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + CH_ONE;
            // Results beyond the plan or past counter saturation are consumed but never numbered.
            if (plan_hit || (acc_q == CNT_MAX)) begin
                err_d = 1'b1;
            end else begin
                fifo_push = 1'b1;
                acc_d     = acc_q + CNT_ONE;
                if (ch_ok[gnt_idx]) begin
                    pass_d = pass_q + CNT_ONE;
                end else begin
                    fail_d = fail_q + CNT_ONE;
                end
            end
        end

        if (plan_we) begin
            if (state_q == IDLE) begin
                plan_d = plan_i;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if ((plan_q != '0) && (acc_d == plan_q) && fifo_drains) begin
                    state_d = DONE;
                end
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            plan_q  <= CNTW'(NUM_TESTS);
            acc_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            plan_q  <= plan_d;
            acc_q   <= acc_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
        end
    end

    peripheral_tap_fifo #(
        .WIDTH (RECW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat (push_rec),
        .pop      (out_ready),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Record fields read as zero whenever no record is presented.
    assign head_rec  = fifo_head;
    assign out_valid = !fifo_empty;
    assign out_index = out_valid ? head_rec.index : '0;
    assign out_ok    = out_valid ? head_rec.ok    : 1'b0;
    assign out_chan  = out_valid ? head_rec.chan  : '0;
    assign out_id    = out_valid ? head_rec.id    : '0;

    assign pass_cnt = pass_q;
    assign fail_cnt = fail_q;
    assign done     = (state_q == DONE);
    assign plan_err = err_q;

endmodule
